// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use / branch-operand hazard controller beside the ID stage
// Inserts LOAD_LAT bubbles per load-use, stalls ID branches on producers, holds on mem wait.
module hazard_ctrl_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter bit BRANCH_IN_ID = 1'b1,
    parameter int PERF_W       = 16,
    localparam int CNT_W       = $clog2(LOAD_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [REG_W-1:0]  id_ex_rd,
    input  logic              ex_mem_mem_read,
    input  logic [REG_W-1:0]  ex_mem_rd,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              if_id_is_branch,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall_mux,
    output logic              if_id_flush,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [PERF_W-1:0] perf_stalls
);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_perf;

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_lu_haz;
    logic w_br_haz;
    logic w_bubble;

    // Register 0 is hardwired zero, so it can never carry a dependency.
    function automatic logic f_src_hit(input logic [REG_W-1:0] x);
        return (x != '0) && ((x == if_id_rs) || (if_id_uses_rt && (x == if_id_rt)));
    endfunction

    assign w_ex_hit  = f_src_hit(id_ex_rd);
    assign w_mem_hit = f_src_hit(ex_mem_rd);
    assign w_lu_haz  = id_ex_mem_read && w_ex_hit;
    assign w_br_haz  = BRANCH_IN_ID && if_id_is_branch &&
                       ((id_ex_reg_write && w_ex_hit) || (ex_mem_mem_read && w_mem_hit));
    assign w_bubble  = !mem_busy && ((r_state == LU_STALL) || w_lu_haz || w_br_haz);

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        stall_mux   = 1'b0;
        if_id_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
        end else if (mem_busy) begin
            // Frozen, not killed: the ID instruction keeps its control signals.
            pipe_hold = 1'b1;
            stall_mux = 1'b1;
        end else if (!w_bubble) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            stall_mux   = 1'b1;
            if_id_flush = branch_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_perf  <= '0;
        end else if (!mem_busy) begin
            case (r_state)
                RUN: begin
                    if (w_lu_haz && (LOAD_LAT > 1)) begin
                        r_state <= LU_STALL;
                        r_cnt   <= CNT_W'(LOAD_LAT - 1);
                    end
                end
                LU_STALL: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
            if (w_bubble && (r_perf != '1)) begin
                r_perf <= r_perf + PERF_W'(1);
            end
        end
    end

    assign stall_cnt   = r_cnt;
    assign perf_stalls = r_perf;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit across four parameter sets
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic [4:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic       if_id_uses_rt, if_id_is_branch, branch_taken, mem_busy;

    logic [3:0] pc_v, ifw_v, mux_v, fl_v, hold_v;
    logic [0:0] sc0, sc2;
    logic [1:0] sc1, sc3;
    logic [15:0] pf0, pf1, pf2;
    logic [3:0]  pf3;
    int sc_v[4];
    int pf_v[4];

    int errors = 0;
    int checks = 0;
    int rem_m[4];
    int perf_m[4];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(1'b1), .PERF_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_v[0]), .if_id_write(ifw_v[0]), .stall_mux(mux_v[0]), .if_id_flush(fl_v[0]),
        .pipe_hold(hold_v[0]), .stall_cnt(sc0), .perf_stalls(pf0));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .BRANCH_IN_ID(1'b1), .PERF_W(16)) dut1 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_v[1]), .if_id_write(ifw_v[1]), .stall_mux(mux_v[1]), .if_id_flush(fl_v[1]),
        .pipe_hold(hold_v[1]), .stall_cnt(sc1), .perf_stalls(pf1));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(1'b0), .PERF_W(16)) dut2 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_v[2]), .if_id_write(ifw_v[2]), .stall_mux(mux_v[2]), .if_id_flush(fl_v[2]),
        .pipe_hold(hold_v[2]), .stall_cnt(sc2), .perf_stalls(pf2));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .BRANCH_IN_ID(1'b1), .PERF_W(4)) dut3 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_is_branch(if_id_is_branch), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_v[3]), .if_id_write(ifw_v[3]), .stall_mux(mux_v[3]), .if_id_flush(fl_v[3]),
        .pipe_hold(hold_v[3]), .stall_cnt(sc3), .perf_stalls(pf3));

    assign sc_v[0] = int'(sc0);
    assign sc_v[1] = int'(sc1);
    assign sc_v[2] = int'(sc2);
    assign sc_v[3] = int'(sc3);
    assign pf_v[0] = int'(pf0);
    assign pf_v[1] = int'(pf1);
    assign pf_v[2] = int'(pf2);
    assign pf_v[3] = int'(pf3);

    function automatic int ll_of(input int k);
        return (k == 1 || k == 3) ? 3 : 1;
    endfunction

    function automatic int pmax_of(input int k);
        return (k == 3) ? 15 : 65535;
    endfunction

    function automatic bit hit(input logic [4:0] x);
        return (x != 5'd0) && (x == if_id_rs || (if_id_uses_rt && x == if_id_rt));
    endfunction

    function automatic bit lu_now();
        return id_ex_mem_read && hit(id_ex_rd);
    endfunction

    function automatic bit br_now(input int k);
        return (k != 2) && if_id_is_branch &&
               ((id_ex_reg_write && hit(id_ex_rd)) || (ex_mem_mem_read && hit(ex_mem_rd)));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bubbles still owed and bubble count, advanced once per unheld clock.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                rem_m[k]  <= 0;
                perf_m[k] <= 0;
            end
        end else if (!mem_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (rem_m[k] > 0) rem_m[k] <= rem_m[k] - 1;
                else if (lu_now()) rem_m[k] <= ll_of(k) - 1;
                if ((rem_m[k] > 0 || lu_now() || br_now(k)) && perf_m[k] < pmax_of(k))
                    perf_m[k] <= perf_m[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int e_pc, e_mux, e_fl, e_hold;
            bit bub;
            bub = (rem_m[k] > 0) || lu_now() || br_now(k);
            if (reset) begin
                e_pc = 0; e_mux = 0; e_fl = 0; e_hold = 0;
            end else if (mem_busy) begin
                e_pc = 0; e_mux = 1; e_fl = 0; e_hold = 1;
            end else if (bub) begin
                e_pc = 0; e_mux = 0; e_fl = 0; e_hold = 0;
            end else begin
                e_pc = 1; e_mux = 1; e_fl = int'(branch_taken); e_hold = 0;
            end
            chk($sformatf("m%0d.pc_write", k), int'(pc_v[k]), e_pc);
            chk($sformatf("m%0d.if_id_write", k), int'(ifw_v[k]), e_pc);
            chk($sformatf("m%0d.stall_mux", k), int'(mux_v[k]), e_mux);
            chk($sformatf("m%0d.if_id_flush", k), int'(fl_v[k]), e_fl);
            chk($sformatf("m%0d.pipe_hold", k), int'(hold_v[k]), e_hold);
            chk($sformatf("m%0d.stall_cnt", k), sc_v[k], rem_m[k]);
            chk($sformatf("m%0d.perf_stalls", k), pf_v[k], perf_m[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0;
        ex_mem_mem_read = 0; ex_mem_rd = 0;
        if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0;
        if_id_is_branch = 0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic rst_pulse();
        set_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = rd; if_id_rs = rd;
    endtask

    initial begin
        set_idle();
        repeat (2) tick();
        chk("rst.pc_write", int'(pc_v[0]), 0);
        chk("rst.stall_mux", int'(mux_v[1]), 0);
        chk("rst.perf", pf_v[1], 0);
        reset = 0;
        #1 chk("rst_rel.pc_write", int'(pc_v[0]), 1);
        tick();

        // load-use, LOAD_LAT 1 and 3
        rst_pulse();
        set_lu(5'd5);
        #1 chk("lu.pc0", int'(pc_v[0]), 0); chk("lu.mux1", int'(mux_v[1]), 0); chk("lu.cnt1", sc_v[1], 0);
        tick(); set_idle();
        #1 chk("lu+1.pc0", int'(pc_v[0]), 1); chk("lu+1.pc1", int'(pc_v[1]), 0);
        chk("lu+1.cnt1", sc_v[1], 2); chk("lu+1.perf0", pf_v[0], 1);
        tick();
        #1 chk("lu+2.cnt1", sc_v[1], 1); chk("lu+2.pc1", int'(pc_v[1]), 0);
        tick();
        #1 chk("lu+3.cnt1", sc_v[1], 0); chk("lu+3.pc1", int'(pc_v[1]), 1); chk("lu+3.perf1", pf_v[1], 3);
        id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs = 0;
        #1 chk("rd0.pc0", int'(pc_v[0]), 1); chk("rd0.pc1", int'(pc_v[1]), 1);
        tick();
        id_ex_rd = 5; if_id_rs = 3; if_id_rt = 5; if_id_uses_rt = 0;
        #1 chk("rt_unused.pc0", int'(pc_v[0]), 1);
        tick();
        if_id_uses_rt = 1;
        #1 chk("rt_used.pc0", int'(pc_v[0]), 0);
        tick(); set_idle();
        repeat (3) tick();

        // branch operand hazards
        rst_pulse();
        if_id_is_branch = 1; if_id_rs = 8; id_ex_reg_write = 1; id_ex_rd = 8;
        #1 chk("br_alu.pc0", int'(pc_v[0]), 0); chk("br_alu.pc2", int'(pc_v[2]), 1);
        tick();
        id_ex_reg_write = 0; id_ex_rd = 0; ex_mem_mem_read = 1; ex_mem_rd = 8;
        #1 chk("br_memld.pc0", int'(pc_v[0]), 0); chk("br_memld.pc2", int'(pc_v[2]), 1);
        tick();
        ex_mem_mem_read = 0;
        #1 chk("br_clear.pc0", int'(pc_v[0]), 1);
        tick();
        id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = 8;
        #1 chk("br_lw_ex.pc2", int'(pc_v[2]), 0);
        tick();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0; ex_mem_mem_read = 1; ex_mem_rd = 8;
        #1 chk("br_lw_mem.pc0", int'(pc_v[0]), 0); chk("br_lw_mem.pc2", int'(pc_v[2]), 1);
        tick();
        ex_mem_mem_read = 0;
        #1 chk("br_done.pc0", int'(pc_v[0]), 1); chk("br_done.perf0", pf_v[0], 4);
        tick(); set_idle();
        repeat (3) tick();

        // mem_busy during LU_STALL
        rst_pulse();
        set_lu(5'd5);
        tick(); set_idle(); mem_busy = 1;
        #1 chk("busy.hold1", int'(hold_v[1]), 1); chk("busy.mux1", int'(mux_v[1]), 1);
        chk("busy.cnt1", sc_v[1], 2); chk("busy.perf1", pf_v[1], 1);
        repeat (3) tick();
        #1 chk("busy4.cnt1", sc_v[1], 2); chk("busy4.perf1", pf_v[1], 1);
        tick(); mem_busy = 0;
        #1 chk("rel.mux1", int'(mux_v[1]), 0); chk("rel.cnt1", sc_v[1], 2);
        tick();
        #1 chk("rel+1.cnt1", sc_v[1], 1); chk("rel+1.mux1", int'(mux_v[1]), 0);
        tick();
        #1 chk("rel+2.pc1", int'(pc_v[1]), 1); chk("rel+2.perf1", pf_v[1], 3);
        tick();

        // flush on taken branch
        rst_pulse();
        branch_taken = 1;
        #1 chk("flush.fl0", int'(fl_v[0]), 1);
        tick();
        if_id_is_branch = 1; if_id_rs = 8; id_ex_reg_write = 1; id_ex_rd = 8;
        #1 chk("flush_haz.fl0", int'(fl_v[0]), 0); chk("flush_haz.mux0", int'(mux_v[0]), 0);
        tick();
        if_id_is_branch = 0; id_ex_reg_write = 0; mem_busy = 1;
        #1 chk("flush_busy.fl0", int'(fl_v[0]), 0);
        tick(); set_idle();
        #1 chk("flush_off.fl0", int'(fl_v[0]), 0);
        tick();

        // async reset mid-stall, then perf saturation
        rst_pulse();
        set_lu(5'd5);
        tick(); set_idle();
        tick();
        #1 chk("pre_rst.cnt1", sc_v[1], 1);
        #1 reset = 1;
        #1 chk("arst.pc1", int'(pc_v[1]), 0); chk("arst.mux1", int'(mux_v[1]), 0);
        chk("arst.cnt1", sc_v[1], 0); chk("arst.perf1", pf_v[1], 0); chk("arst.hold1", int'(hold_v[1]), 0);
        tick(); reset = 0;
        #1 chk("arst_rel.pc1", int'(pc_v[1]), 1); chk("arst_rel.cnt1", sc_v[1], 0);
        tick();
        set_lu(5'd7);
        repeat (20) tick();
        #1 chk("sat.perf3", pf_v[3], 15);
        set_idle();
        repeat (4) tick();
        #1 chk("sat_hold.perf3", pf_v[3], 15);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised load-use / branch hazard controller for the pipelined MIPS core. It replaces the single-cycle combinational load-use detector with a small FSM that does four things: inserts LOAD_LAT bubbles per load-use hazard, stalls compare-in-ID branches on in-flight producers, freezes the pipe on data-memory wait, and flushes IF/ID on taken branches. It sits beside the ID stage and drives the PC enable, the IF/ID enable/flush and the control-bubble mux select.

Parameters:
REG_W, 5, register-address width
LOAD_LAT, 1, bubbles inserted per load-use hazard (>=1)
BRANCH_IN_ID, 1, 1 = enable branch-operand hazard detection in ID; 0 = branch checks disabled
PERF_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_reg_write  in  1  instruction in EX writes a register
id_ex_rd  in  REG_W  destination register of EX instruction (already Rt/Rd-muxed)
ex_mem_mem_read  in  1  instruction in MEM is a load
ex_mem_rd  in  REG_W  destination register of MEM instruction
if_id_rs  in  REG_W  Rs of instruction in ID
if_id_rt  in  REG_W  Rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads Rt as a source
if_id_is_branch  in  1  ID instruction is beq/bne (compares in ID)
branch_taken  in  1  ID branch resolved taken this cycle
mem_busy  in  1  data memory not ready; whole pipe must hold
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
stall_mux  out  1  1 = pass ID control to ID/EX, 0 = insert bubble (zero control)
if_id_flush  out  1  clear IF/ID to NOP on next edge
pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB
stall_cnt  out  $clog2(LOAD_LAT+1)  remaining load-use bubbles (debug)
perf_stalls  out  PERF_W  total bubble cycles since reset, saturating

Behaviour:
- Match rule: src_hit(x) = (x != 0) && (x == if_id_rs || (if_id_uses_rt && x == if_id_rt)). Register 0 never causes a hazard.
- lu_haz = id_ex_mem_read && src_hit(id_ex_rd).
- br_haz = BRANCH_IN_ID && if_id_is_branch && ((id_ex_reg_write && src_hit(id_ex_rd)) || (ex_mem_mem_read && src_hit(ex_mem_rd))).
- States: RUN, LU_STALL, plus a counter cnt.
- RUN:
  - On lu_haz: bubble this cycle (pc_write=0, if_id_write=0, stall_mux=0).
  - If LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
- LU_STALL:
  - Bubble every cycle; cnt decrements each unheld cycle.
  - When cnt reaches 1 and is consumed, return to RUN with cnt=0. Total bubbles = LOAD_LAT exactly.
- br_haz in RUN, no lu_haz: one bubble. Combinational; it re-evaluates next cycle, so a load in MEM yields the required second bubble naturally.
- Priority: mem_busy > LU_STALL > lu_haz > br_haz > flush.
- mem_busy=1:
  - pipe_hold=1, pc_write=0, if_id_write=0, stall_mux=1 (no bubble; the instruction is frozen, not killed).
  - State, cnt and perf_stalls all hold.
- if_id_flush = branch_taken && no stall && !mem_busy. A stalled branch is not yet valid, so flush is suppressed.
- No hazard: pc_write=1, if_id_write=1, stall_mux=1, if_id_flush=0, pipe_hold=0.
- perf_stalls increments on every cycle with stall_mux=0 && !mem_busy; it saturates at all-ones.
- Reset (async, any state):
  - State=RUN, cnt=0, perf_stalls=0.
  - While reset is high, outputs are forced to pc_write=0, if_id_write=0, stall_mux=0, if_id_flush=0, pipe_hold=0.
  - Reset asserted mid-LU_STALL abandons the remaining bubbles.
- Outputs are combinational from state and inputs; state updates on posedge clk.

Test Plan:
1. LOAD_LAT=1: lw $5 in EX (id_ex_mem_read=1, id_ex_rd=5), ID reads rs=5 -> exactly 1 cycle of pc_write=0/if_id_write=0/stall_mux=0, then all 1; perf_stalls=1.
2. LOAD_LAT=3, same hazard -> 3 consecutive bubble cycles, stall_cnt sequence 0→2→1→0, perf_stalls=3. With rd=0, or with rt=5 and if_id_uses_rt=0 -> no bubble.
3. beq reading $8: ALU op in EX writing $8 -> 1 bubble; load in MEM with ex_mem_rd=8 -> 1 bubble; lw $8 in EX followed into MEM -> 2 bubbles total. With BRANCH_IN_ID=0 -> no bubble for ALU producer.
4. mem_busy=1 for 4 cycles during LU_STALL (LOAD_LAT=3, cnt=2) -> pipe_hold=1, stall_mux=1, cnt frozen at 2, perf_stalls unchanged. After release, the remaining 2 bubbles complete.
5. branch_taken=1, no hazard -> if_id_flush=1 for one cycle. branch_taken=1 coincident with br_haz -> if_id_flush=0 and stall_mux=0.
6. Assert reset during LU_STALL (cnt=1) -> immediately forced reset outputs, perf_stalls=0. After release, RUN with pc_write=1 when no hazard. Also force perf_stalls to saturate with PERF_W=4 -> holds at 15.
